ex_muldiv: RTL and testbench

Multi-cycle HI/LO multiply/divide unit in the EX stage. It consumes the operands and function code delivered by the ID/EX pipeline register. It also drives the stall request back to the PC, IF/ID and ID/EX stages while an iterative operation is in flight, and owns the architectural HI/LO registers read by MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_iter_core.sv | 74 +++++++
 rtl/ex_muldiv.sv | 130 +++++++++++++
 tb/tb_ex_muldiv.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the EX-stage HI/LO multiply/divide unit: function codes,
// controller state encoding and the iteration count of the multi-cycle datapath.
package muldiv_pkg;

    localparam int ITER_STEPS = 32;

    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath on unsigned magnitudes: restoring division or shift-add
// multiply, one step per cycle, with its own step counter.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             mul_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shr_q, shr_d;
    logic [WIDTH-1:0] opb_q;
    logic             mul_q;
    logic [4:0]       cnt_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Divide: acc is the partial remainder, shr shifts the dividend out and the
    // quotient in. Multiply: {acc, shr} shifts right as the product accumulates.
    always_comb begin
        acc_d   = acc_q;
        shr_d   = shr_q;
        sum     = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opb_q} : '0);
        shifted = {acc_q, shr_q[WIDTH-1]};
        diff    = shifted - {1'b0, opb_q};
        if (mul_q) begin
            acc_d = sum[WIDTH:1];
            shr_d = {sum[0], shr_q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_d = diff[WIDTH-1:0];
            shr_d = {shr_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = shifted[WIDTH-1:0];
            shr_d = {shr_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            shr_q <= '0;
            opb_q <= '0;
            mul_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= '0;
            shr_q <= a_i;
            opb_q <= b_i;
            mul_q <= mul_i;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_d;
            shr_q <= shr_d;
            cnt_q <= cnt_q + 5'd1;
        end
    end

    // The outputs already include the step being taken this cycle.
    assign last_o = (cnt_q == 5'(ITER_STEPS - 1));
    assign hi_o   = acc_d;
    assign lo_o   = shr_d;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO multiply/divide unit: controller FSM, sign handling, HI/LO.
// Optional MULDIV_ITER_MUL_EN routes MULT/MULTU through the iterative core.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] rdata_a,
    input  logic [WIDTH-1:0] rdata_b,
    input  logic             flush,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MULDIV_ITER_MUL_EN
    localparam bit ITER_MUL = 1'b1;
`else
    localparam bit ITER_MUL = 1'b0;
`endif

    state_e             state_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;
    logic               neg_q_q, neg_r_q, op_mul_q;

    logic               is_mul, is_div, is_signed, a_neg, b_neg;
    logic               can_accept, iter_go;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] prod_abs, prod_fix, iter_prod;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               core_last;
    logic [WIDTH-1:0]   core_hi, core_lo;

    always_comb begin
        is_mul     = (func == FUNC_MULT) || (func == FUNC_MULTU);
        is_div     = (func == FUNC_DIV)  || (func == FUNC_DIVU);
        is_signed  = (func == FUNC_MULT) || (func == FUNC_DIV);
        a_neg      = is_signed & rdata_a[WIDTH-1];
        b_neg      = is_signed & rdata_b[WIDTH-1];
        a_abs      = a_neg ? -rdata_a : rdata_a;
        b_abs      = b_neg ? -rdata_b : rdata_b;
        prod_abs   = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
        prod_fix   = (a_neg ^ b_neg) ? -prod_abs : prod_abs;
        can_accept = !rst && start && !flush && (state_q != ST_BUSY);
        iter_go    = can_accept && ((is_div && (rdata_b != '0)) || (is_mul && ITER_MUL));
        stall_req  = !rst && ((state_q == ST_BUSY) || iter_go);
        iter_prod  = neg_q_q ? -{core_hi, core_lo} : {core_hi, core_lo};
        quo_fix    = neg_q_q ? -core_lo : core_lo;
        rem_fix    = neg_r_q ? -core_hi : core_hi;
    end

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load_i (iter_go),
        .step_i ((state_q == ST_BUSY) && !flush),
        .mul_i  (is_mul),
        .a_i    (a_abs),
        .b_i    (b_abs),
        .last_o (core_last),
        .hi_o   (core_hi),
        .lo_o   (core_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            op_mul_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BUSY: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else if (core_last) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        if (op_mul_q) begin
                            {hi_q, lo_q} <= iter_prod;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end
                end
                default: begin
                    // DONE accepts new work exactly like IDLE.
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    if (iter_go) begin
                        state_q  <= ST_BUSY;
                        neg_q_q  <= a_neg ^ b_neg;
                        neg_r_q  <= a_neg;
                        op_mul_q <= is_mul;
                    end else if (can_accept) begin
                        if (is_mul) begin
                            {hi_q, lo_q} <= prod_fix;
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                        end else if (is_div) begin
                            hi_q    <= rdata_a;
                            lo_q    <= '1;
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (func == FUNC_MTHI) begin
                            hi_q <= rdata_a;
                        end else if (func == FUNC_MTLO) begin
                            lo_q <= rdata_a;
                        end
                    end
                end
            endcase
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed corner cases plus randomized ops, checked
// against an arithmetic model of HI/LO and the expected stall/done timing.
module tb_ex_muldiv;

`ifdef MULDIV_ITER_MUL_EN
  localparam bit TB_ITER_MUL = 1'b1;
`else
  localparam bit TB_ITER_MUL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [5:0]  func;
  logic [31:0] rdata_a, rdata_b;
  logic        stall_req, done;
  logic [31:0] hi, lo;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mh, ml;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .func      (func),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .flush     (flush),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns 0 = no completion pulse, 1 = single-cycle, 2 = iterative.
  function automatic int ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p;
    int          kind;
    kind = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      6'h18: begin
        p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; kind = TB_ITER_MUL ? 2 : 1;
      end
      6'h19: begin
        p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; kind = TB_ITER_MUL ? 2 : 1;
      end
      6'h1A, 6'h1B: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; kind = 1;
        end else begin
          if (f == 6'h1A) begin
            q = sa / sb; r = sa % sb;
          end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
          end
          p = 64'(q); l = p[31:0];
          p = 64'(r); h = p[31:0];
          kind = 2;
        end
      end
      6'h11: h = a;
      6'h13: l = a;
      default: ;
    endcase
    return kind;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts at the current negedge (cycle 0); returns in the done cycle, or
  // at the last watched cycle when no pulse is expected.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int abort_cyc, input bit abort_rst);
    logic [31:0] nh, nl;
    int kind, max_c, exp_done, exp_stall, done_cyc, stall_cnt;
    nh = mh; nl = ml; done_cyc = -1; stall_cnt = 0;
    kind = ref_op(f, a, b, nh, nl);
    if (abort_cyc == 0) begin
      exp_done = -1; exp_stall = 0; max_c = 2;
      if (abort_rst) begin mh = '0; ml = '0; end
    end else if (abort_cyc > 0 && kind == 2) begin
      exp_done = -1; exp_stall = abort_cyc + (abort_rst ? 0 : 1); max_c = 40;
      if (abort_rst) begin mh = '0; ml = '0; end
    end else begin
      mh = nh; ml = nl;
      case (kind)
        2:       begin exp_done = 33; exp_stall = 33; max_c = 40; end
        1:       begin exp_done = 1;  exp_stall = 0;  max_c = 40; end
        default: begin exp_done = -1; exp_stall = 0;  max_c = 1;  end
      endcase
    end
    start = 1'b1; func = f; rdata_a = a; rdata_b = b;
    flush = (abort_cyc == 0) && !abort_rst;
    rst   = (abort_cyc == 0) && abort_rst;
    #1;
    if (stall_req) stall_cnt++;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0; rst = 1'b0;
      func = 6'($urandom_range(0, 63)); rdata_a = $urandom; rdata_b = $urandom;
      if (c == abort_cyc) begin
        if (abort_rst) rst = 1'b1;
        else flush = 1'b1;
      end
      #1;
      if (stall_req) stall_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    flush = 1'b0; rst = 1'b0;
    check_val({name, " hi"}, 64'(hi), 64'(mh));
    check_val({name, " lo"}, 64'(lo), 64'(ml));
    check_val({name, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check_val({name, " stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] f;
    logic [5:0] funcs [7];
    funcs = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h00};
    rst = 1'b1; start = 1'b0; flush = 1'b0; func = '0; rdata_a = '0; rdata_b = '0;
    mh = '0; ml = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("reset hi", 64'(hi), 64'd0);
    check_val("reset lo", 64'(lo), 64'd0);
    check_val("reset done", 64'(done), 64'd0);
    check_val("reset stall", 64'(stall_req), 64'd0);
    idle(1);

    run_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0); idle(1);
    run_op("mult_neg",  6'h18, 32'hFFFF_FFFD, 32'h0000_0007, -1, 1'b0); idle(1);
    run_op("div_neg",   6'h1A, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b0); idle(1);
    run_op("div_ovf",   6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0); idle(1);
    run_op("divu_zero", 6'h1B, 32'd5, 32'd0, -1, 1'b0); idle(1);
    run_op("divu_flush", 6'h1B, 32'd100, 32'd7, 10, 1'b0); idle(1);
    run_op("flush_accept", 6'h1B, 32'd100, 32'd7, 0, 1'b0); idle(1);
    run_op("divu_rst",  6'h1B, 32'd100, 32'd7, 10, 1'b1); idle(1);
    run_op("mthi",      6'h11, 32'h1234_5678, 32'd0, -1, 1'b0); idle(1);
    run_op("mtlo",      6'h13, 32'h9ABC_DEF0, 32'd0, -1, 1'b0); idle(1);
    run_op("b2b_first", 6'h1B, 32'd100, 32'd7, -1, 1'b0);
    run_op("b2b_second", 6'h1B, 32'd1000, 32'd3, -1, 1'b0);
    run_op("b2b_mult",  6'h18, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    run_op("b2b_div0",  6'h1A, 32'hDEAD_BEEF, 32'd0, -1, 1'b0); idle(2);

    for (int i = 0; i < 60; i++) begin
      f = funcs[$urandom_range(0, 6)];
      if (f == 6'h00) f = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0)
        run_op("rand_flush", f, pick_operand(), pick_operand(), $urandom_range(2, 32), 1'b0);
      else
        run_op("rand", f, pick_operand(), pick_operand(), -1, 1'b0);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
